quad_encoder_decoder: RTL and testbench
=======================================

Name: quad_encoder_decoder

Overview:
- Receive side of the motor drive path; the PWM driver commands the motor, and this block reads back the motor's quadrature encoder (channels A/B).
- Synchronises and deglitches A/B, decodes X4 quadrature steps, and keeps a signed wrapping position count.
- Reports direction and per-window speed, and flags illegal transitions to the control logic.

Parameters:
- POS_W, 16, position counter width (signed, two's complement)
- SPD_W, 16, speed output width (signed, saturating)
- FILT_LEN, 3, consecutive identical synced samples required before a channel's filtered level changes (min 1)
- WINDOW_CYCLES, 50000, speed gate length in clk cycles (1 ms at 50 MHz; min 2)

Ports:
- clk, input, 1, 50 MHz system clock
- reset, input, 1, synchronous active-high reset
- enc_a, input, 1, encoder channel A (asynchronous)
- enc_b, input, 1, encoder channel B (asynchronous)
- pos_clear, input, 1, single-cycle request to zero position
- error_clear, input, 1, clears sticky enc_error
- position, output, POS_W, signed accumulated step count
- direction, output, 1, last valid step direction; 1 = clockwise, 0 = anticlockwise
- step_valid, output, 1, one-cycle pulse per counted step
- speed, output, SPD_W, signed steps counted in last completed window
- speed_valid, output, 1, one-cycle pulse when speed updates
- enc_error, output, 1, sticky illegal-transition flag

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - position = 0, direction = 1, step_valid = 0, speed = 0, speed_valid = 0, enc_error = 0.
  - Sync and filter regs = 0, window counter = 0, accumulator = 0, primed = 0.
- Input path:
  - Each channel passes through a 2-flop synchroniser, then a filter.
  - The filter's output takes the synced level once that level has differed from the current output for FILT_LEN consecutive cycles.
  - Any bounce restarts the filter count.
- Priming:
  - After reset, the first filter cycle where the filter counts have expired sets primed = 1.
  - That cycle captures the current AB level as the baseline; no step and no error are generated.
- Decode: compare previous and current filtered {A,B} each cycle.
  - Clockwise (+1) sequence: 00->01->11->10->00.
  - Reverse of that sequence: -1.
  - No change: none.
  - Both bits changed: error. Set enc_error, no count, direction unchanged.
- Latency: an edge on enc_a/enc_b held stable produces step_valid and the updated position FILT_LEN+3 cycles after the first clk edge that samples it (6 cycles at default).
- Position:
  - Update position += ±1, modulo 2^POS_W: 0x7FFF+1 -> 0x8000, and 0x0000-1 -> 0xFFFF.
  - On each valid step, direction = 1 for +1 and 0 for -1.
  - pos_clear sets position to 0 next cycle; if a step occurs in the same cycle, clear wins and the step is discarded from position.
  - A step discarded by pos_clear still counts toward speed.
- Speed:
  - The window counter runs 0..WINDOW_CYCLES-1 continuously from reset.
  - A signed accumulator sums steps, saturating at ±(2^(SPD_W-1)-1).
  - On the terminal count cycle:
    - speed <= saturate(acc + step_this_cycle), acc <= 0.
    - speed_valid pulses high for exactly 1 cycle, then the counter wraps to 0.
  - pos_clear does not affect speed.
- Error:
  - enc_error is sticky until error_clear.
  - If error_clear and a new error occur in the same cycle, enc_error stays 1.
- Reset mid-operation: all state returns to reset values next edge, and re-priming is required; no spurious step.

Decomposition:
- Package motor_pkg:
  - step_t enum {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR}.
  - Constants DIR_CW = 1 and DIR_ACW = 0 (shared with the PWM driver direction input).
- Sub-module enc_input_filter:
  - Per-channel synchroniser plus FILT_LEN stability counter.
  - Instantiated twice (A, B).
- Top module holds decode, position, speed window and error logic.

Test Plan:
- Bench parameters: WINDOW_CYCLES = 100, FILT_LEN = 3, 50 MHz clock.
- Reset then idle AB = 11 for 20 cycles -> position 0, no step_valid, enc_error 0 (priming produces no count).
- Drive 8 clockwise transitions (00,01,11,10,...) each held 10 cycles -> position = 8, direction = 1, 8 step_valid pulses, each 6 cycles after its edge. Then 3 reverse transitions -> position = 5, direction = 0.
- Load near wrap via 1 reverse step from 0 -> position 0xFFFF; then 1 clockwise step -> 0x0000.
- Glitch: pulse enc_a for 2 cycles -> no step; jump AB 00->11 -> enc_error = 1, position unchanged. Assert error_clear -> enc_error = 0.
- Speed: 10 clockwise steps in one window -> speed = 10 with a 1-cycle speed_valid at cycle 99 of the window. An idle next window -> speed = 0.
- pos_clear coincident with a step -> position = 0, window speed still includes the step; assert reset mid-window -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared motor-drive types: quadrature step classification and direction encoding.
// The direction constants match the PWM driver's direction input.
package motor_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } step_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_ACW = 1'b0;

  // X4 decode. Clockwise order is 00 -> 01 -> 11 -> 10 -> 00.
  // Any change of both bits at once is not a legal quadrature transition.
  function automatic step_t decode_step(input logic [1:0] prev_ab,
                                        input logic [1:0] curr_ab);
    step_t res;
    case ({prev_ab, curr_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: res = STEP_FWD;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: res = STEP_REV;
      default: res = (prev_ab == curr_ab) ? STEP_NONE : STEP_ERR;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// One encoder channel: 2-flop synchroniser followed by a stability filter.
// `ready` rises once enough cycles have passed since reset for `level` to track the pin.
module enc_input_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic enc_in,
  output logic level,
  output logic ready
);

  localparam int CNT_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int WARM   = FILT_LEN + 2;
  localparam int WARM_W = $clog2(WARM + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FILT_LEN - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM);

  logic              sync_p0;
  logic              sync_p1;
  logic [CNT_W-1:0]  stable_cnt;
  logic [WARM_W-1:0] warm_cnt;

  assign ready = (warm_cnt == WARM_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
      warm_cnt   <= '0;
    end else begin
      sync_p0 <= enc_in;
      sync_p1 <= sync_p0;

      // Level follows only after FILT_LEN consecutive differing samples; any bounce restarts.
      if (sync_p1 != level) begin
        if (stable_cnt == CNT_LAST) begin
          level      <= sync_p1;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end

      if (!ready) begin
        warm_cnt <= warm_cnt + WARM_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder readback: filtered A/B inputs, X4 decode, wrapping position,
// windowed speed measurement and a sticky illegal-transition flag.
module quad_encoder_decoder
  import motor_pkg::*;
#(
  parameter int POS_W         = 16,
  parameter int SPD_W         = 16,
  parameter int FILT_LEN      = 3,
  parameter int WINDOW_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    pos_clear,
  input  logic                    error_clear,
  output logic signed [POS_W-1:0] position,
  output logic                    direction,
  output logic                    step_valid,
  output logic signed [SPD_W-1:0] speed,
  output logic                    speed_valid,
  output logic                    enc_error
);

  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  localparam logic signed [SPD_W:0]   SUM_MAX = $signed({2'b00, {(SPD_W-1){1'b1}}});
  localparam logic signed [SPD_W:0]   SUM_MIN = -SUM_MAX;
  localparam logic signed [SPD_W-1:0] SPD_MAX = SUM_MAX[SPD_W-1:0];
  localparam logic signed [SPD_W-1:0] SPD_MIN = SUM_MIN[SPD_W-1:0];

  function automatic logic signed [SPD_W-1:0] sat_add(input logic signed [SPD_W-1:0] a,
                                                      input logic signed [1:0]       d);
    logic signed [SPD_W:0] sum;
    sum = $signed({a[SPD_W-1], a}) + $signed({{(SPD_W-1){d[1]}}, d});
    if (sum > SUM_MAX) begin
      return SPD_MAX;
    end else if (sum < SUM_MIN) begin
      return SPD_MIN;
    end
    return sum[SPD_W-1:0];
  endfunction

  logic              filt_a;
  logic              filt_b;
  logic              rdy_a;
  logic              rdy_b;
  logic [1:0]        ab_p0;
  logic [1:0]        prev_ab;
  logic              primed;
  step_t             step_p0;
  step_t             step_p1;
  logic signed [1:0] step_delta;
  logic [WIN_W-1:0]  win_cnt;
  logic signed [SPD_W-1:0] acc;

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk    (clk),
    .reset  (reset),
    .enc_in (enc_a),
    .level  (filt_a),
    .ready  (rdy_a)
  );

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk    (clk),
    .reset  (reset),
    .enc_in (enc_b),
    .level  (filt_b),
    .ready  (rdy_b)
  );

  // ---- stage p0 -> p1: decode against the previous filtered level ----
  assign ab_p0   = {filt_a, filt_b};
  assign step_p0 = decode_step(prev_ab, ab_p0);

  always_ff @(posedge clk) begin
    if (reset) begin
      primed  <= 1'b0;
      prev_ab <= 2'b00;
      step_p1 <= STEP_NONE;
    end else if (!primed) begin
      // First valid filtered sample is only a baseline, never a step.
      step_p1 <= STEP_NONE;
      if (rdy_a && rdy_b) begin
        primed  <= 1'b1;
        prev_ab <= ab_p0;
      end
    end else begin
      prev_ab <= ab_p0;
      step_p1 <= step_p0;
    end
  end

  // ---- stage p1 -> p2: position, direction, error, speed ----
  always_comb begin
    step_delta = 2'sb00;
    case (step_p1)
      STEP_FWD: step_delta = 2'sb01;
      STEP_REV: step_delta = 2'sb11;
      default:  step_delta = 2'sb00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      position   <= '0;
      direction  <= DIR_CW;
      step_valid <= 1'b0;
      enc_error  <= 1'b0;
    end else begin
      step_valid <= (step_p1 == STEP_FWD) || (step_p1 == STEP_REV);

      // Clear takes priority over a coincident step.
      if (pos_clear) begin
        position <= '0;
      end else if (step_p1 == STEP_FWD) begin
        position <= position + POS_W'(1);
      end else if (step_p1 == STEP_REV) begin
        position <= position - POS_W'(1);
      end

      if (step_p1 == STEP_FWD) begin
        direction <= DIR_CW;
      end else if (step_p1 == STEP_REV) begin
        direction <= DIR_ACW;
      end

      if (step_p1 == STEP_ERR) begin
        enc_error <= 1'b1;
      end else if (error_clear) begin
        enc_error <= 1'b0;
      end
    end
  end

  // Steps discarded by pos_clear still count here.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt     <= '0;
      acc         <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      if (win_cnt == WIN_LAST) begin
        win_cnt     <= '0;
        acc         <= '0;
        speed       <= sat_add(acc, step_delta);
        speed_valid <= 1'b1;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        acc     <= sat_add(acc, step_delta);
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Directed bench for quad_encoder_decoder with WINDOW_CYCLES = 100 and FILT_LEN = 3.
module tb_quad_encoder_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enc_a;
  logic        enc_b;
  logic        pos_clear;
  logic        error_clear;
  logic [15:0] position;
  logic        direction;
  logic        step_valid;
  logic [15:0] speed;
  logic        speed_valid;
  logic        enc_error;

  int          checks = 0;
  int          failures = 0;
  int          sv_count = 0;
  logic [1:0]  ab;
  logic [15:0] exp_pos;
  logic        obs_pre, obs_on, obs_post, obs_dir;
  logic [15:0] obs_pos;

  quad_encoder_decoder #(
    .POS_W         (16),
    .SPD_W         (16),
    .FILT_LEN      (3),
    .WINDOW_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .pos_clear   (pos_clear),
    .error_clear (error_clear),
    .position    (position),
    .direction   (direction),
    .step_valid  (step_valid),
    .speed       (speed),
    .speed_valid (speed_valid),
    .enc_error   (enc_error)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (step_valid === 1'b1) sv_count <= sv_count + 1;
  end

  function automatic logic [1:0] cw_next(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] acw_next(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic set_ab(input logic [1:0] v);
    enc_a = v[1];
    enc_b = v[0];
    ab    = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a level, observe step_valid just before, at, and after its expected cycle.
  task automatic drive_step(input logic [1:0] v, input int hold);
    set_ab(v);
    wait_cyc(6);
    obs_pre = step_valid;
    wait_cyc(1);
    obs_on  = step_valid;
    obs_pos = position;
    obs_dir = direction;
    wait_cyc(1);
    obs_post = step_valid;
    wait_cyc(hold - 8);
  endtask

  // Returns the number of cycles waited until speed_valid is seen high (or limit).
  task automatic wait_speed_valid(input int limit, output int n);
    n = 0;
    while (speed_valid !== 1'b1 && n < limit) begin
      wait_cyc(1);
      n++;
    end
  endtask

  task automatic test_reset;
    int s0;
    wait_cyc(3);
    checks++; if (position !== 16'h0000) begin failures++; $display("FAIL reset_position got=%h exp=0000", position); end
    checks++; if (direction !== 1'b1) begin failures++; $display("FAIL reset_direction got=%b exp=1", direction); end
    checks++; if (step_valid !== 1'b0) begin failures++; $display("FAIL reset_step_valid got=%b exp=0", step_valid); end
    checks++; if (speed !== 16'h0000) begin failures++; $display("FAIL reset_speed got=%h exp=0000", speed); end
    checks++; if (speed_valid !== 1'b0) begin failures++; $display("FAIL reset_speed_valid got=%b exp=0", speed_valid); end
    checks++; if (enc_error !== 1'b0) begin failures++; $display("FAIL reset_enc_error got=%b exp=0", enc_error); end
    reset = 1'b0;
    s0 = sv_count;
    wait_cyc(21);
    checks++; if (position !== 16'h0000) begin failures++; $display("FAIL prime_position got=%h exp=0000", position); end
    checks++; if (sv_count != s0) begin failures++; $display("FAIL prime_no_step got=%0d exp=0", sv_count - s0); end
    checks++; if (enc_error !== 1'b0) begin failures++; $display("FAIL prime_enc_error got=%b exp=0", enc_error); end
    exp_pos = 16'h0000;
  endtask

  task automatic test_cw_steps;
    int s0;
    s0 = sv_count;
    for (int i = 0; i < 8; i++) begin
      drive_step(cw_next(ab), 10);
      exp_pos = exp_pos + 16'd1;
      checks++; if (obs_pre !== 1'b0) begin failures++; $display("FAIL cw_early_step%0d got=%b exp=0", i, obs_pre); end
      checks++; if (obs_on !== 1'b1) begin failures++; $display("FAIL cw_step_valid%0d got=%b exp=1", i, obs_on); end
      checks++; if (obs_pos !== exp_pos) begin failures++; $display("FAIL cw_position%0d got=%h exp=%h", i, obs_pos, exp_pos); end
      checks++; if (obs_post !== 1'b0) begin failures++; $display("FAIL cw_pulse_width%0d got=%b exp=0", i, obs_post); end
    end
    wait_cyc(1);
    checks++; if (sv_count - s0 != 8) begin failures++; $display("FAIL cw_pulse_count got=%0d exp=8", sv_count - s0); end
    checks++; if (position !== 16'd8) begin failures++; $display("FAIL cw_final_position got=%h exp=0008", position); end
    checks++; if (direction !== 1'b1) begin failures++; $display("FAIL cw_direction got=%b exp=1", direction); end
  endtask

  task automatic test_rev_steps;
    for (int i = 0; i < 3; i++) begin
      drive_step(acw_next(ab), 10);
      exp_pos = exp_pos - 16'd1;
      checks++; if (obs_on !== 1'b1) begin failures++; $display("FAIL rev_step_valid%0d got=%b exp=1", i, obs_on); end
      checks++; if (obs_pos !== exp_pos) begin failures++; $display("FAIL rev_position%0d got=%h exp=%h", i, obs_pos, exp_pos); end
      checks++; if (obs_dir !== 1'b0) begin failures++; $display("FAIL rev_direction%0d got=%b exp=0", i, obs_dir); end
    end
    checks++; if (position !== 16'd5) begin failures++; $display("FAIL rev_final_position got=%h exp=0005", position); end
  endtask

  task automatic test_wrap;
    pos_clear = 1'b1;
    wait_cyc(1);
    pos_clear = 1'b0;
    checks++; if (position !== 16'h0000) begin failures++; $display("FAIL wrap_clear got=%h exp=0000", position); end
    drive_step(acw_next(ab), 10);
    checks++; if (obs_pos !== 16'hFFFF) begin failures++; $display("FAIL wrap_under got=%h exp=ffff", obs_pos); end
    checks++; if (obs_dir !== 1'b0) begin failures++; $display("FAIL wrap_under_dir got=%b exp=0", obs_dir); end
    drive_step(cw_next(ab), 10);
    checks++; if (obs_pos !== 16'h0000) begin failures++; $display("FAIL wrap_over got=%h exp=0000", obs_pos); end
    checks++; if (obs_dir !== 1'b1) begin failures++; $display("FAIL wrap_over_dir got=%b exp=1", obs_dir); end
    exp_pos = 16'h0000;
  endtask

  task automatic test_glitch_error;
    int s0;
    logic [1:0] orig;
    orig = ab;
    s0 = sv_count;
    set_ab({~orig[1], orig[0]});
    wait_cyc(2);
    set_ab(orig);
    wait_cyc(12);
    checks++; if (sv_count != s0) begin failures++; $display("FAIL glitch_no_step got=%0d exp=0", sv_count - s0); end
    checks++; if (position !== 16'h0000) begin failures++; $display("FAIL glitch_position got=%h exp=0000", position); end
    checks++; if (enc_error !== 1'b0) begin failures++; $display("FAIL glitch_enc_error got=%b exp=0", enc_error); end

    drive_step(2'b00, 10);
    exp_pos = 16'd1;
    checks++; if (obs_pos !== 16'd1) begin failures++; $display("FAIL err_setup_position got=%h exp=0001", obs_pos); end
    s0 = sv_count;
    set_ab(2'b11);
    wait_cyc(10);
    checks++; if (enc_error !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", enc_error); end
    checks++; if (position !== 16'd1) begin failures++; $display("FAIL err_position got=%h exp=0001", position); end
    checks++; if (direction !== 1'b1) begin failures++; $display("FAIL err_direction got=%b exp=1", direction); end
    checks++; if (sv_count != s0) begin failures++; $display("FAIL err_no_step got=%0d exp=0", sv_count - s0); end
    error_clear = 1'b1;
    wait_cyc(1);
    error_clear = 1'b0;
    checks++; if (enc_error !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", enc_error); end
  endtask

  task automatic test_speed;
    int n;
    wait_speed_valid(250, n);
    checks++; if (speed_valid !== 1'b1) begin failures++; $display("FAIL speed_sync_timeout got=%b exp=1", speed_valid); end
    for (int i = 0; i < 10; i++) begin
      set_ab(cw_next(ab));
      wait_cyc(6);
    end
    exp_pos = exp_pos + 16'd10;
    wait_speed_valid(240, n);
    checks++; if (n + 60 != 100) begin failures++; $display("FAIL speed_window_len got=%0d exp=100", n + 60); end
    checks++; if (speed !== 16'd10) begin failures++; $display("FAIL speed_ten got=%h exp=000a", speed); end
    checks++; if (position !== exp_pos) begin failures++; $display("FAIL speed_position got=%h exp=%h", position, exp_pos); end
    wait_cyc(1);
    checks++; if (speed_valid !== 1'b0) begin failures++; $display("FAIL speed_valid_width got=%b exp=0", speed_valid); end
    wait_speed_valid(300, n);
    checks++; if (n + 1 != 100) begin failures++; $display("FAIL speed_idle_window_len got=%0d exp=100", n + 1); end
    checks++; if (speed !== 16'd0) begin failures++; $display("FAIL speed_idle got=%h exp=0000", speed); end
  endtask

  task automatic test_clear_with_step;
    int n;
    set_ab(cw_next(ab));
    wait_cyc(6);
    pos_clear = 1'b1;
    wait_cyc(1);
    pos_clear = 1'b0;
    checks++; if (position !== 16'h0000) begin failures++; $display("FAIL clear_wins got=%h exp=0000", position); end
    exp_pos = 16'h0000;
    wait_cyc(3);
    wait_speed_valid(200, n);
    checks++; if (speed !== 16'd1) begin failures++; $display("FAIL clear_step_speed got=%h exp=0001", speed); end
  endtask

  task automatic test_reset_mid;
    int s0;
    drive_step(acw_next(ab), 10);
    set_ab(2'b11);
    wait_cyc(8);
    checks++; if (position !== 16'hFFFF) begin failures++; $display("FAIL mid_pre_position got=%h exp=ffff", position); end
    checks++; if (enc_error !== 1'b1) begin failures++; $display("FAIL mid_pre_error got=%b exp=1", enc_error); end
    reset = 1'b1;
    wait_cyc(1);
    checks++; if (position !== 16'h0000) begin failures++; $display("FAIL mid_position got=%h exp=0000", position); end
    checks++; if (direction !== 1'b1) begin failures++; $display("FAIL mid_direction got=%b exp=1", direction); end
    checks++; if (step_valid !== 1'b0) begin failures++; $display("FAIL mid_step_valid got=%b exp=0", step_valid); end
    checks++; if (speed !== 16'h0000) begin failures++; $display("FAIL mid_speed got=%h exp=0000", speed); end
    checks++; if (speed_valid !== 1'b0) begin failures++; $display("FAIL mid_speed_valid got=%b exp=0", speed_valid); end
    checks++; if (enc_error !== 1'b0) begin failures++; $display("FAIL mid_enc_error got=%b exp=0", enc_error); end
    reset = 1'b0;
    s0 = sv_count;
    wait_cyc(25);
    checks++; if (sv_count != s0) begin failures++; $display("FAIL mid_reprime_step got=%0d exp=0", sv_count - s0); end
    checks++; if (position !== 16'h0000) begin failures++; $display("FAIL mid_reprime_position got=%h exp=0000", position); end
    checks++; if (enc_error !== 1'b0) begin failures++; $display("FAIL mid_reprime_error got=%b exp=0", enc_error); end
  endtask

  initial begin
    reset       = 1'b1;
    pos_clear   = 1'b0;
    error_clear = 1'b0;
    exp_pos     = 16'h0000;
    set_ab(2'b11);
    test_reset;
    test_cw_steps;
    test_rev_steps;
    test_wrap;
    test_glitch_error;
    test_speed;
    test_clear_with_step;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
